pipeline_register_em: RTL and testbench

- Execute-to-memory pipeline register. Sits directly downstream of the decode/execute register and the ALU.
- Latches execute results and control, and owns the data-cache request for the instruction currently in the memory stage.
- Small FSM holds dREN/dWEN until dhit, then drops them so a request is never reissued. Reports mem_busy to the hazard unit.
- Captures load data and makes halt sticky.

---
 rtl/pipeline_register_em.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_register_em.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register_em.sv
// ---------------------------------------------------------------------------
// pipeline_register_em
//   Execute-to-memory pipeline register. Latches execute results and
//   control, owns the data-cache request of the instruction now in the
//   memory stage, captures load data and keeps halt sticky.
//
//   Handshake: the register advances (load) only when ihit=1, stall=0 and
//   no memory request is outstanding. A latched load/store raises dREN/dWEN
//   and mem_busy until the cycle dhit=1 is seen; the request is then
//   dropped and never reissued for that instruction.
//
// Ports
//   CLK, nRST                  clock (rising edge), async active-low reset
//   ihit, stall, flush         advance qualifier, hold, bubble insert
//   dhit, dmemload             data cache completion and read data
//   alu_out .. halt            execute-stage results and control
//   n_*                        registered copies presented to memory/WB
//   dREN, dWEN                 data cache request
//   dmemaddr, dmemstore        cache address / store data
//   mem_busy                   memory op outstanding (to hazard unit)
//   fsm_state                  debug view of the request FSM
// ---------------------------------------------------------------------------
module pipeline_register_em #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              stall,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [WORD_W-1:0] store_dat,
    input  logic [WORD_W-1:0] next_memaddr,
    input  logic [WORD_W-1:0] utype,
    input  logic [4:0]        wsel,
    input  logic [2:0]        final_mux,
    input  logic              Reg_write,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic              atomic,
    input  logic              halt,
    output logic [WORD_W-1:0] n_alu_out,
    output logic [WORD_W-1:0] n_store_dat,
    output logic [WORD_W-1:0] n_next_memaddr,
    output logic [WORD_W-1:0] n_utype,
    output logic [4:0]        n_wsel,
    output logic [2:0]        n_final_mux,
    output logic              n_Reg_write,
    output logic              n_atomic,
    output logic              n_halt,
    output logic [WORD_W-1:0] n_dmemload,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_busy,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_PEND = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] alu_out_q, alu_out_d;
    logic [WORD_W-1:0] store_dat_q, store_dat_d;
    logic [WORD_W-1:0] next_memaddr_q, next_memaddr_d;
    logic [WORD_W-1:0] utype_q, utype_d;
    logic [WORD_W-1:0] dmemload_q, dmemload_d;
    logic [4:0]        wsel_q, wsel_d;
    logic [2:0]        final_mux_q, final_mux_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              atomic_q, atomic_d;
    logic              halt_q, halt_d;

    logic pend;
    logic load;

    assign pend = (state_q == MEM_PEND);
    // mem_busy gates load, so a new instruction can never overwrite the
    // one whose cache request is still in flight.
    assign load = ihit & ~stall & ~pend;

    always_comb begin
        state_d        = state_q;
        alu_out_d      = alu_out_q;
        store_dat_d    = store_dat_q;
        next_memaddr_d = next_memaddr_q;
        utype_d        = utype_q;
        dmemload_d     = dmemload_q;
        wsel_d         = wsel_q;
        final_mux_d    = final_mux_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        atomic_d       = atomic_q;
        halt_d         = halt_q;

        if (load) begin
            if (flush) begin
                // Bubble: everything clears except halt, which is sticky.
                alu_out_d      = '0;
                store_dat_d    = '0;
                next_memaddr_d = '0;
                utype_d        = '0;
                dmemload_d     = '0;
                wsel_d         = '0;
                final_mux_d    = '0;
                reg_write_d    = 1'b0;
                mem_read_d     = 1'b0;
                mem_write_d    = 1'b0;
                atomic_d       = 1'b0;
                state_d        = IDLE;
            end else begin
                alu_out_d      = alu_out;
                store_dat_d    = store_dat;
                next_memaddr_d = next_memaddr;
                utype_d        = utype;
                wsel_d         = wsel;
                final_mux_d    = final_mux;
                reg_write_d    = Reg_write;
                mem_read_d     = Mem_Read;
                mem_write_d    = Mem_Write;
                atomic_d       = atomic;
                halt_d         = halt_q | halt;
                state_d        = (Mem_Read | Mem_Write) ? MEM_PEND : IDLE;
            end
        end else if (pend && dhit) begin
            // Completion wins over a same-cycle ihit; advance comes later.
            if (mem_read_q) begin
                dmemload_d = dmemload;
            end
            state_d = MEM_DONE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            alu_out_q      <= '0;
            store_dat_q    <= '0;
            next_memaddr_q <= '0;
            utype_q        <= '0;
            dmemload_q     <= '0;
            wsel_q         <= '0;
            final_mux_q    <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            atomic_q       <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            alu_out_q      <= alu_out_d;
            store_dat_q    <= store_dat_d;
            next_memaddr_q <= next_memaddr_d;
            utype_q        <= utype_d;
            dmemload_q     <= dmemload_d;
            wsel_q         <= wsel_d;
            final_mux_q    <= final_mux_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            atomic_q       <= atomic_d;
            halt_q         <= halt_d;
        end
    end

    // Request lines come straight from registered bits, so an async reset
    // drops them without waiting for a clock edge.
    assign dREN           = pend & mem_read_q;
    assign dWEN           = pend & mem_write_q;
    assign mem_busy       = pend;
    assign fsm_state      = state_q;

    assign n_alu_out      = alu_out_q;
    assign n_store_dat    = store_dat_q;
    assign n_next_memaddr = next_memaddr_q;
    assign n_utype        = utype_q;
    assign n_wsel         = wsel_q;
    assign n_final_mux    = final_mux_q;
    assign n_Reg_write    = reg_write_q;
    assign n_atomic       = atomic_q;
    assign n_halt         = halt_q;
    assign n_dmemload     = dmemload_q;
    assign dmemaddr       = alu_out_q;
    assign dmemstore      = store_dat_q;

endmodule

// File: tb/tb_pipeline_register_em.sv
// ---------------------------------------------------------------------------
// tb_pipeline_register_em
//   Directed bench for the execute-to-memory register. A behavioural model
//   tracks "the instruction in the memory stage", whether its cache request
//   is still outstanding, the captured load data and the sticky halt; a
//   compare process checks every DUT output against it each cycle. Directed
//   steps add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_pipeline_register_em;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic         ihit, stall, flush, dhit;
    logic [W-1:0] dmemload, alu_out, store_dat, next_memaddr, utype;
    logic [4:0]   wsel;
    logic [2:0]   final_mux;
    logic         Reg_write, Mem_Read, Mem_Write, atomic, halt;

    logic [W-1:0] n_alu_out, n_store_dat, n_next_memaddr, n_utype, n_dmemload;
    logic [4:0]   n_wsel;
    logic [2:0]   n_final_mux;
    logic         n_Reg_write, n_atomic, n_halt;
    logic         dREN, dWEN, mem_busy;
    logic [W-1:0] dmemaddr, dmemstore;
    logic [1:0]   fsm_state;

    pipeline_register_em #(.WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .flush(flush),
        .dhit(dhit), .dmemload(dmemload), .alu_out(alu_out),
        .store_dat(store_dat), .next_memaddr(next_memaddr), .utype(utype),
        .wsel(wsel), .final_mux(final_mux), .Reg_write(Reg_write),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .atomic(atomic),
        .halt(halt), .n_alu_out(n_alu_out), .n_store_dat(n_store_dat),
        .n_next_memaddr(n_next_memaddr), .n_utype(n_utype), .n_wsel(n_wsel),
        .n_final_mux(n_final_mux), .n_Reg_write(n_Reg_write),
        .n_atomic(n_atomic), .n_halt(n_halt), .n_dmemload(n_dmemload),
        .dREN(dREN), .dWEN(dWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_busy(mem_busy), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The memory-stage instruction, whether its request is outstanding,
    // the last captured load word and the sticky halt.
    logic [W-1:0] m_alu, m_sd, m_nma, m_ut, m_ld;
    logic [4:0]   m_wsel;
    logic [2:0]   m_fm;
    logic         m_rw, m_rd, m_wr, m_at, m_halt, m_busy;

    task automatic model_clear_instr();
        m_alu = '0; m_sd = '0; m_nma = '0; m_ut = '0; m_ld = '0;
        m_wsel = '0; m_fm = '0; m_rw = 0; m_rd = 0; m_wr = 0; m_at = 0;
        m_busy = 0;
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            model_clear_instr();
            m_halt = 0;
        end else if (ihit && !stall && !m_busy) begin
            if (flush) begin
                model_clear_instr();
            end else begin
                m_alu = alu_out; m_sd = store_dat; m_nma = next_memaddr;
                m_ut = utype; m_wsel = wsel; m_fm = final_mux;
                m_rw = Reg_write; m_rd = Mem_Read; m_wr = Mem_Write;
                m_at = atomic; m_halt = m_halt | halt;
                m_busy = Mem_Read | Mem_Write;
            end
        end else if (m_busy && dhit) begin
            if (m_rd) m_ld = dmemload;
            m_busy = 0;
        end
    end

    task automatic compare_all();
        chk("n_alu_out", n_alu_out, m_alu);
        chk("n_store_dat", n_store_dat, m_sd);
        chk("n_next_memaddr", n_next_memaddr, m_nma);
        chk("n_utype", n_utype, m_ut);
        chk("n_wsel", n_wsel, m_wsel);
        chk("n_final_mux", n_final_mux, m_fm);
        chk("n_Reg_write", n_Reg_write, m_rw);
        chk("n_atomic", n_atomic, m_at);
        chk("n_halt", n_halt, m_halt);
        chk("n_dmemload", n_dmemload, m_ld);
        chk("dREN", dREN, m_busy & m_rd);
        chk("dWEN", dWEN, m_busy & m_wr);
        chk("mem_busy", mem_busy, m_busy);
        chk("dmemaddr", dmemaddr, m_alu);
        chk("dmemstore", dmemstore, m_sd);
        chk("fsm_pend", fsm_state == 2'd1, m_busy);
    endtask

    // Compare process: sample 2 time units after each rising edge.
    always @(posedge CLK) begin
        #2;
        compare_all();
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ihit = 0; stall = 0; flush = 0; dhit = 0; dmemload = '0;
        alu_out = '0; store_dat = '0; next_memaddr = '0; utype = '0;
        wsel = '0; final_mux = '0; Reg_write = 0; Mem_Read = 0;
        Mem_Write = 0; atomic = 0; halt = 0;
    endtask

    task automatic instr(input logic [W-1:0] a, input logic [W-1:0] sd,
                         input logic [4:0] ws, input logic rd, input logic wr,
                         input logic rw, input logic ht);
        alu_out = a; store_dat = sd; next_memaddr = a + 32'd4;
        utype = {a[19:0], 12'h000}; wsel = ws; final_mux = {rd, wr, rw};
        Reg_write = rw; Mem_Read = rd; Mem_Write = wr; atomic = ws[0]; halt = ht;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        repeat (2) tick();
        chk("reset_dREN", dREN, 0);
        chk("reset_mem_busy", mem_busy, 0);
        chk("reset_n_alu_out", n_alu_out, 0);
        nRST = 1'b1;
        tick();

        // Load flow
        ihit = 1; instr(32'h100, 32'h0, 5'd3, 1, 0, 1, 0);
        tick();
        chk("load_dREN", dREN, 1);
        chk("load_dmemaddr", dmemaddr, 32'h100);
        chk("load_mem_busy", mem_busy, 1);
        instr(32'h200, 32'h11, 5'd4, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_dmemaddr", dmemaddr, 32'h100);
            chk("wait_dREN", dREN, 1);
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        tick();
        chk("dhit_n_dmemload", n_dmemload, 32'hDEADBEEF);
        chk("dhit_dREN", dREN, 0);
        chk("dhit_mem_busy", mem_busy, 0);
        chk("dhit_no_advance", n_alu_out, 32'h100);
        dhit = 0; dmemload = 32'h0BADF00D;
        tick();
        chk("next_n_alu_out", n_alu_out, 32'h200);
        chk("next_n_wsel", n_wsel, 5'd4);

        // Store with simultaneous ihit/dhit
        instr(32'h40, 32'h55, 5'd5, 0, 1, 0, 0);
        tick();
        chk("store_dWEN", dWEN, 1);
        chk("store_dmemstore", dmemstore, 32'h55);
        instr(32'h80, 32'h66, 5'd6, 0, 0, 1, 0);
        dhit = 1; dmemload = 32'h12345678;
        tick();
        chk("store_dhit_dWEN", dWEN, 0);
        chk("store_hold_alu", n_alu_out, 32'h40);
        chk("store_no_dmemload", n_dmemload, 32'hDEADBEEF);
        dhit = 0;
        tick();
        chk("store_next_alu", n_alu_out, 32'h80);

        // Flush
        flush = 1; instr(32'h300, 32'h0, 5'd7, 1, 0, 1, 0);
        tick();
        chk("flush_n_Reg_write", n_Reg_write, 0);
        chk("flush_n_wsel", n_wsel, 0);
        chk("flush_dREN", dREN, 0);
        chk("flush_fsm_idle", fsm_state, 2'd0);
        flush = 0;

        // Stall hold (one stalled cycle also asserts flush)
        instr(32'h1234, 32'h9, 5'd9, 0, 0, 1, 0);
        tick();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            instr($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 1, 1);
            flush = (i == 2);
            tick();
            chk("stall_n_alu_out", n_alu_out, 32'h1234);
            chk("stall_n_halt", n_halt, 0);
        end
        stall = 0; flush = 0;

        // Sticky halt
        instr(32'h500, 32'h0, 5'd1, 0, 0, 0, 1);
        tick();
        chk("halt_set", n_halt, 1);
        flush = 1; instr(32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        tick();
        flush = 0;
        instr(32'h600, 32'h0, 5'd2, 0, 0, 1, 0);
        tick();
        chk("halt_sticky", n_halt, 1);

        // Mixed short sequence: immediate dhit, ihit gaps, read then write
        for (int i = 0; i < 24; i++) begin
            ihit = 1'($urandom_range(0, 3) != 0);
            dhit = 1'($urandom_range(0, 1));
            dmemload = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 7) == 0);
            instr(32'h1000 + 32'(i * 4), 32'(i), 5'(i), 1'(i % 3 == 0), 1'(i % 3 == 1), 1, 0);
            tick();
        end

        // Reset mid-request
        idle_inputs();
        ihit = 1; instr(32'h700, 32'h0, 5'd8, 1, 0, 1, 0);
        tick();
        ihit = 0; Mem_Read = 0;
        chk("pre_reset_dREN", dREN, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_dREN", dREN, 0);
        chk("async_dWEN", dWEN, 0);
        chk("async_mem_busy", mem_busy, 0);
        chk("async_n_alu_out", n_alu_out, 0);
        chk("async_n_halt", n_halt, 0);
        chk("async_n_dmemload", n_dmemload, 0);
        tick();
        nRST = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
